aes_key_schedule_seq: RTL

Sequential, parametrised AES key schedule generator. Expands a 128/192/256-bit cipher key into the full set of Nr+1 128-bit round keys, one 32-bit word per clock. Each round key is streamed out with a valid strobe and index. It sits between the key input and the round-key store feeding the encryption datapath, and replaces the single-step combinational expansion with a full-schedule engine for all three key sizes.

---
 rtl/aes_key_schedule_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule_seq.sv
// AES key schedule engine: expands a 128/192/256-bit key into NR+1 round
// keys, one 32-bit word per clock, streaming each round key with a strobe.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset
//   i_start     begin expansion (sampled only when idle)
//   i_key_in    cipher key, word 0 in the MSBs (sampled on accepted start)
//   o_busy      expansion in progress
//   o_rk_valid  one-cycle strobe, o_rk/o_rk_index valid
//   o_rk_index  round-key number 0..NR
//   o_rk        round key {w[4j], w[4j+1], w[4j+2], w[4j+3]}
//   o_done      one-cycle pulse after the final round key

// Byte S-box: 256-entry table packed row-major, entry 0 in the MSBs.
module aes_sbox (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x occupies bits [2047-8x -: 8] = [{~x, 3'b111} -: 8].
    assign o_y = TBL[{~i_x, 3'b111} -: 8];
endmodule

module aes_key_schedule_seq #(
    parameter int NK = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [32*NK-1:0]  i_key_in,
    output logic              o_busy,
    output logic              o_rk_valid,
    output logic [3:0]        o_rk_index,
    output logic [127:0]      o_rk,
    output logic              o_done
);
    localparam int NR = NK + 6;
    localparam logic [5:0] KLAST = 6'(4 * (NR + 1) - 1);
    localparam logic [2:0] KMODLAST = 3'(NK - 1);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("aes_key_schedule_seq: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_FIN} state_t;

    state_t           r_state;
    // Sliding window of the last NK words: oldest (w[k-NK]) in the MSBs.
    logic [32*NK-1:0] r_win;
    logic [95:0]      r_acc;
    logic [5:0]       r_k;
    logic [2:0]       r_kmod;
    // High while k < NK: words come straight from the loaded key.
    logic             r_init;
    logic [7:0]       r_rcon;

    logic [31:0] w_old;
    logic [31:0] w_prev;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [31:0] w_word;
    logic [7:0]  w_xt;

    assign w_old    = r_win[32*NK-1 -: 32];
    assign w_prev   = r_win[31:0];
    assign w_sub_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]}
                                       : w_prev;

    // Single SubWord shared between the rotate and the NK=8 mid-step.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_x (w_sub_in[8*gi +: 8]),
                .o_y (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_temp = w_prev;
        if (r_kmod == 3'd0)
            w_temp = w_sub ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_kmod == 3'd4)
            w_temp = w_sub;
    end

    // During the key pass the window rotates, so w_old is key word k.
    assign w_word = r_init ? w_old : (w_old ^ w_temp);
    assign w_xt   = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_win      <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_kmod     <= '0;
            r_init     <= 1'b0;
            r_rcon     <= 8'h01;
            o_busy     <= 1'b0;
            o_rk_valid <= 1'b0;
            o_rk_index <= '0;
            o_rk       <= '0;
            o_done     <= 1'b0;
        end else begin
            o_rk_valid <= 1'b0;
            o_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_GEN;
                        o_busy  <= 1'b1;
                        r_win   <= i_key_in;
                        r_k     <= '0;
                        r_kmod  <= '0;
                        r_init  <= 1'b1;
                        r_rcon  <= 8'h01;
                    end
                end
                S_GEN: begin
                    r_win  <= {r_win[32*NK-33:0], w_word};
                    r_acc  <= {r_acc[63:0], w_word};
                    r_k    <= r_k + 6'd1;
                    r_kmod <= (r_kmod == KMODLAST) ? 3'd0 : r_kmod + 3'd1;
                    if (r_kmod == KMODLAST)
                        r_init <= 1'b0;
                    if (!r_init && r_kmod == 3'd0)
                        r_rcon <= w_xt;
                    if (r_k[1:0] == 2'b11) begin
                        o_rk_valid <= 1'b1;
                        o_rk       <= {r_acc, w_word};
                        o_rk_index <= r_k[5:2];
                    end
                    if (r_k == KLAST)
                        r_state <= S_FIN;
                end
                S_FIN: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
